// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: multiplexed NUM_DIGITS hex 7-segment driver with PWM brightness,
// anti-ghosting guard blanking and frame-synchronous input latching.
// Optional leading-zero blanking is enabled by defining SEG_LZ_BLANK_EN.
module seven_seg_scanner #(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 65536,
    parameter int GUARD_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [4*NUM_DIGITS-1:0] val,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [3:0]              brightness,
    output logic [7:0]              segments,
    output logic [NUM_DIGITS-1:0]   digitselect,
    output logic                    frame_tick
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PW = CW + 5;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [PW-1:0] ACT_LEN  = PW'(SCAN_DIV - GUARD_CYCLES);
    localparam logic [PW-1:0] GRD_LEN  = PW'(GUARD_CYCLES);
    localparam logic [1:0] PH_GUARD = 2'd0;
    localparam logic [1:0] PH_ON    = 2'd1;
    localparam logic [1:0] PH_OFF   = 2'd2;

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] val_s;
    logic [NUM_DIGITS-1:0]   dp_s;
    logic [NUM_DIGITS-1:0]   en_s;
    logic [3:0]              bri_s;
    logic                    slot_start;
    logic                    frame_start;
    logic [NUM_DIGITS-1:0]   en_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [4*NUM_DIGITS-1:0] val_c;
    logic [NUM_DIGITS-1:0]   dp_c;
    logic [NUM_DIGITS-1:0]   en_c;
    logic [3:0]              bri_c;
    logic [PW-1:0]           on_len;
    logic [PW-1:0]           cnt_w;
    logic [1:0]              phase;
    logic [3:0]              nib;
    logic [6:0]              glyph;
    logic [7:0]              seg_d;
    logic [NUM_DIGITS-1:0]   sel_d;
    logic [NUM_DIGITS-1:0]   one_hot;

    function automatic logic [6:0] encode(input logic [3:0] n);
        case (n)
            4'h0: encode = 7'b1000000;
            4'h1: encode = 7'b1111001;
            4'h2: encode = 7'b0100100;
            4'h3: encode = 7'b0110000;
            4'h4: encode = 7'b0011001;
            4'h5: encode = 7'b0010010;
            4'h6: encode = 7'b0000010;
            4'h7: encode = 7'b1111000;
            4'h8: encode = 7'b0000000;
            4'h9: encode = 7'b0010000;
            4'hA: encode = 7'b0001000;
            4'hB: encode = 7'b0000011;
            4'hC: encode = 7'b1000110;
            4'hD: encode = 7'b0100001;
            4'hE: encode = 7'b0000110;
            default: encode = 7'b0001110;
        endcase
    endfunction

    assign slot_start  = cnt == '0;
    assign frame_start = slot_start && idx == '0;

`ifdef SEG_LZ_BLANK_EN
    logic [NUM_DIGITS-1:0] lz;

    // A digit is a leading zero when it and every more-significant nibble are zero; digit 0 always shows
    always_comb begin
        lz = '0;
        lz[NUM_DIGITS-1] = val[4*NUM_DIGITS-1 -: 4] == 4'd0;
        for (int i = NUM_DIGITS - 2; i >= 0; i--) lz[i] = lz[i+1] && val[4*i +: 4] == 4'd0;
        lz[0] = 1'b0;
    end

    assign en_in = digit_en & ~lz;
    assign dp_in = dp & ~lz;
`else
    assign en_in = digit_en;
    assign dp_in = dp;
`endif

    // On latch cycles the outputs see the values being latched, so the slot never uses stale data
    assign val_c = frame_start ? val : val_s;
    assign dp_c  = frame_start ? dp_in : dp_s;
    assign en_c  = frame_start ? en_in : en_s;
    assign bri_c = slot_start ? brightness : bri_s;

    // Duty length at full width so the shift never loses high bits
    assign on_len = (ACT_LEN * (PW'(bri_c) + PW'(1))) >> 4;
    assign cnt_w  = PW'(cnt);

    // Slot phase: blank guard, lit window sized by brightness, then blank remainder
    always_comb begin
        phase = (cnt_w < GRD_LEN) ? PH_GUARD : (cnt_w < GRD_LEN + on_len) ? PH_ON : PH_OFF;
    end

    assign nib   = val_c[{idx, 2'b00} +: 4];
    assign glyph = encode(nib);

    // Next-cycle anode/cathode pattern; at most one anode low and only inside the lit window
    always_comb begin
        one_hot = NUM_DIGITS'(1) << idx;
        seg_d   = (phase == PH_ON) ? {~dp_c[idx], glyph} : 8'hFF;
        sel_d   = (phase == PH_ON && en_c[idx]) ? ~one_hot : '1;
    end

    // Slot counter wraps every SCAN_DIV cycles and advances the digit index
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Shadow registers: display data once per frame, brightness once per slot
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            val_s <= '0;
            dp_s  <= '0;
            en_s  <= '0;
            bri_s <= '0;
        end else begin
            if (frame_start) begin
                val_s <= val;
                dp_s  <= dp_in;
                en_s  <= en_in;
            end
            if (slot_start) bri_s <= brightness;
        end
    end

    // Registered pin drivers; reset blanks the display immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            segments    <= 8'hFF;
            digitselect <= '1;
            frame_tick  <= 1'b0;
        end else begin
            segments    <= seg_d;
            digitselect <= sel_d;
            frame_tick  <= frame_start;
        end
    end
endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
- Parametrised multiplexed 7-segment display driver; successor to the fixed 8-digit scanner.
- Scans NUM_DIGITS hex digits round-robin and adds per-digit decimal points, a per-digit enable mask and a 16-level PWM brightness control.
- Adds anti-ghosting guard blanking between digits and frame-synchronous input latching, so a value never tears mid-frame.
- Sits between the top-level board wrapper and the anode/cathode pins.

Parameters:
- NUM_DIGITS, 8: number of digits scanned, legal range 1..16.
- SCAN_DIV, 65536: clock cycles per digit slot, legal range 32..2^20.
- GUARD_CYCLES, 16: blank cycles at the start of each slot; must be less than SCAN_DIV/2.

Ports:
- clk, input, 1: system clock; all logic on its rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- val, input, 4*NUM_DIGITS: hex value to display; nibble i drives digit i, and digit 0 is the rightmost.
- dp, input, NUM_DIGITS: decimal point request per digit, 1 = lit.
- digit_en, input, NUM_DIGITS: digit enable mask, 1 = shown; a 0 keeps that digit dark.
- brightness, input, 4: duty level 0..15; 15 is full on.
- segments, output, 8: active-low cathodes; [6:0] = g,f,e,d,c,b,a and [7] = decimal point.
- digitselect, output, NUM_DIGITS: active-low anodes, at most one bit low.
- frame_tick, output, 1: one-cycle pulse when the shadow registers load.

Behaviour:
- Reset (reset_n low, asynchronous):
  - cnt=0, idx=0, all shadow registers=0.
  - segments=8'hFF, digitselect=all ones, frame_tick=0.
- Slot counter cnt:
  - Counts 0..SCAN_DIV-1 and wraps.
  - Digit index idx increments on cnt wrap; after NUM_DIGITS-1 it returns to 0.
  - NUM_DIGITS=1 means idx stays 0.
- Frame latch:
  - Condition: cnt==0 and idx==0, including the first cycle after reset release.
  - On that condition val, dp and digit_en are copied into val_s, dp_s and en_s, and frame_tick is asserted for exactly that cycle.
  - Between latches, input changes have no effect on the outputs.
- Brightness:
  - Sampled into bri_s when cnt==0, at the start of every slot.
  - on_len = ((SCAN_DIV-GUARD_CYCLES)*(bri_s+1))>>4, computed at full width with no truncation before the shift.
- Slot phase FSM, evaluated on cnt each cycle:
  - GUARD: cnt < GUARD_CYCLES. All anodes off, segments=8'hFF.
  - ON: GUARD_CYCLES <= cnt < GUARD_CYCLES+on_len. digitselect[idx]=0 if en_s[idx]=1, otherwise all anodes off. segments[6:0]=encode(val_s nibble idx), segments[7]=~dp_s[idx].
  - OFF: all remaining cycles of the slot. All anodes off, segments=8'hFF.
- Latency: outputs are registered, so they reflect the cnt/idx state of the previous cycle (1-cycle latency).
- Encoding, active-low g..a:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Never drive two anodes low simultaneously, including across slot and frame transitions; the guard interval guarantees this.
- Reset asserted mid-slot blanks the outputs immediately (asynchronously). Scanning resumes from idx 0 with a fresh frame latch.

Optional Feature:
- Macro: SEG_LZ_BLANK_EN.
- Defined: at each frame latch, any digit whose nibble and every more-significant nibble of val is zero gets its en_s bit forced to 0. Digit 0 is never suppressed. A digit suppressed this way keeps its decimal point dark too.
- Undefined: no suppression; zero digits show "0" whenever digit_en allows.

Test Plan (NUM_DIGITS=4, SCAN_DIV=64, GUARD_CYCLES=4 unless stated):
1. Hold reset_n low for 5 cycles -> segments=8'hFF, digitselect=4'b1111, frame_tick=0. Release -> frame_tick=1 for exactly one cycle, then again every 256 cycles.
2. val=16'h1234, digit_en=4'hF, dp=0, brightness=15 -> digit 0 low on digitselect for output cycles 5..64 of slot 0 with segments=8'b10011001 ("4"). Digits 1, 2, 3 follow with "3", "2", "1". Each slot has a 4-cycle blank gap between digits and never two anodes low.
3. Change val to 16'hABCD at cycle 100 of a frame -> displayed digits unchanged until the next frame_tick; the frame after shows d, C, b, A.
4. brightness=3 -> each digit active for exactly 15 cycles per slot (on_len=(60*4)>>4). brightness=0 -> exactly 3 cycles.
5. digit_en=4'b1011, dp=4'b0001 -> digitselect[2] never low; segments[7]=0 only while digit 0 is active.
6. val=16'h0050 with SEG_LZ_BLANK_EN defined -> digits 3 and 2 never lit, digits 1 and 0 show "5" and "0". Undefined -> digit 3 shows "0". Separately, val=16'h0000 with the macro defined -> only digit 0 lit, showing "0".
